// File: rtl/reg_xfer_master_pkg.sv
// Shared definitions for the register-file command sequencer:
// opcodes, sequencer state encoding and default widths.
package reg_xfer_master_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 3;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_MOVE  = 2'd2;
    localparam logic [1:0] OP_SWAP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_SWAP_MV,
        ST_SWAP_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/reg_xfer_master_if.sv
// Command/response handshake plus register-file port bundle.
// The master modport is the sequencer's view; slave is the requester/register-file side.
interface reg_xfer_master_if #(
    parameter int DW = reg_xfer_master_pkg::DW_DEFAULT,
    parameter int AW = reg_xfer_master_pkg::AW_DEFAULT
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic [AW-1:0] rf_source;
    logic [AW-1:0] rf_destination;
    logic          rf_move;
    logic          rf_in;
    logic [DW-1:0] rf_data_in;
    logic [DW-1:0] rf_data_out;

    modport master (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rf_data_out,
        output cmd_ready, rsp_valid, rsp_data, busy,
        output rf_source, rf_destination, rf_move, rf_in, rf_data_in
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rf_data_out,
        input  cmd_ready, rsp_valid, rsp_data, busy,
        input  rf_source, rf_destination, rf_move, rf_in, rf_data_in
    );

endinterface

// File: rtl/reg_xfer_master.sv
// Expands WRITE/READ/MOVE/SWAP commands into register-file cycles and returns
// a single-cycle response pulse carrying the write data or the captured read data.
module reg_xfer_master
    import reg_xfer_master_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    reg_xfer_master_if.master bus
);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
    logic [DW-1:0] temp;
    logic [DW-1:0] rsp_data_r;
    logic          accept;

    assign accept       = bus.cmd_valid && (state == ST_IDLE);
    assign bus.rsp_data = rsp_data_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= OP_WRITE;
            src        <= '0;
            dst        <= '0;
            data       <= '0;
            temp       <= '0;
            rsp_data_r <= '0;
        end else begin
            if (accept) begin
                op   <= bus.cmd_op;
                src  <= bus.cmd_src;
                dst  <= bus.cmd_dst;
                data <= bus.cmd_data;
            end
            if (state == ST_CAPTURE) begin
                temp <= bus.rf_data_out;
            end
            // Load the response on entry to DONE so it holds until the next one.
            if (state_nxt == ST_DONE) begin
                if (op == OP_WRITE) begin
                    rsp_data_r <= data;
                end else if (state == ST_CAPTURE) begin
                    rsp_data_r <= bus.rf_data_out;
                end else begin
                    rsp_data_r <= temp;
                end
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        bus.cmd_ready      = 1'b0;
        bus.busy           = 1'b1;
        bus.rsp_valid      = 1'b0;
        bus.rf_in          = 1'b0;
        bus.rf_move        = 1'b0;
        bus.rf_source      = src;
        bus.rf_destination = dst;
        bus.rf_data_in     = '0;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                case (op)
                    OP_WRITE: begin
                        bus.rf_in      = 1'b1;
                        bus.rf_data_in = data;
                        state_nxt      = ST_DONE;
                    end
                    OP_READ: state_nxt = ST_CAPTURE;
                    OP_MOVE: begin
                        bus.rf_move = 1'b1;
                        state_nxt   = ST_CAPTURE;
                    end
                    default: begin
                        bus.rf_source = dst;
                        state_nxt     = ST_CAPTURE;
                    end
                endcase
            end
            // SWAP keeps pointing at dst so the read port stays on the captured register.
            ST_CAPTURE: begin
                if (op == OP_SWAP) begin
                    bus.rf_source = dst;
                    state_nxt     = ST_SWAP_MV;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_SWAP_MV: begin
                bus.rf_move = 1'b1;
                state_nxt   = ST_SWAP_WR;
            end
            ST_SWAP_WR: begin
                bus.rf_in          = 1'b1;
                bus.rf_destination = src;
                bus.rf_data_in     = temp;
                state_nxt          = ST_DONE;
            end
            ST_DONE: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_xfer_master.sv
// Bench for reg_xfer_master: behavioural 8x16 register file as responder,
// array-based reference model of command semantics and latencies.
module tb_reg_xfer_master;
    import reg_xfer_master_pkg::*;

    localparam int DW = 16;
    localparam int AW = 3;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_xfer_master_if #(.DW(DW), .AW(AW)) bus();

    reg_xfer_master #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file responder
    logic [DW-1:0] mem [8];
    logic [DW-1:0] dout;
    logic          dz;

    always @(posedge clk) begin
        if (bus.rf_in) begin
            mem[bus.rf_destination] <= bus.rf_data_in;
            dz <= 1'b1;
        end else begin
            dout <= mem[bus.rf_source];
            dz   <= 1'b0;
            if (bus.rf_move) mem[bus.rf_destination] <= mem[bus.rf_source];
        end
    end

    assign bus.rf_data_out = dz ? 'z : dout;

    // Reference model: register contents as a plain array
    logic [DW-1:0] ref_m [8];

    function automatic cmd_t mk(input logic [1:0] op, input int s, input int d, input logic [DW-1:0] v);
        cmd_t c;
        c.op = op; c.src = AW'(s); c.dst = AW'(d); c.data = v;
        return c;
    endfunction

    task automatic model_apply(input cmd_t c, output int elat, output logic [DW-1:0] ersp);
        logic [DW-1:0] t;
        case (c.op)
            OP_WRITE: begin ref_m[c.dst] = c.data; ersp = c.data; elat = 2; end
            OP_READ:  begin ersp = ref_m[c.src]; elat = 3; end
            OP_MOVE:  begin ersp = ref_m[c.src]; ref_m[c.dst] = ersp; elat = 3; end
            default: begin
                t = ref_m[c.src];
                ersp = ref_m[c.dst];
                ref_m[c.src] = ersp;
                ref_m[c.dst] = t;
                elat = 5;
            end
        endcase
    endtask

    task automatic drive_cmd(input cmd_t c);
        bus.cmd_op   = c.op;
        bus.cmd_src  = c.src;
        bus.cmd_dst  = c.dst;
        bus.cmd_data = c.data;
    endtask

    // Waits (bounded) for ready at negedges; returns with the accept edge just passed (+1).
    task automatic accept_cmd(input cmd_t c, output bit to);
        int w = 0;
        @(negedge clk);
        drive_cmd(c);
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        to = !bus.cmd_ready;
        if (!to) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_cmd(input cmd_t c, output int lat, output logic [DW-1:0] rsp, output bit to);
        accept_cmd(c, to);
        bus.cmd_valid = 1'b0;
        lat = 0;
        rsp = 'x;
        if (!to) begin
            lat = 1;
            while (!bus.rsp_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            to  = !bus.rsp_valid;
            rsp = bus.rsp_data;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        drive_cmd(mk(OP_WRITE, 0, 0, '0));
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.cmd_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.rsp_data !== '0) begin bad++; $display("FAIL rst_rsp_data got=%h want=0", bus.rsp_data); end
        total++;
        if ({bus.rf_in, bus.rf_move, bus.rf_source, bus.rf_destination, bus.rf_data_in} !== '0) begin
            bad++;
            $display("FAIL rst_rf got=%b%b %0d %0d %h want=all zero", bus.rf_in, bus.rf_move,
                     bus.rf_source, bus.rf_destination, bus.rf_data_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input cmd_t seq[$]);
        int lat, elat;
        logic [DW-1:0] rsp, ersp;
        bit to;
        foreach (seq[i]) begin
            run_cmd(seq[i], lat, rsp, to);
            model_apply(seq[i], elat, ersp);
            total++;
            if (to || lat !== elat) begin bad++; $display("FAIL %s_lat[%0d] got=%0d want=%0d", name, i, lat, elat); end
            total++;
            if (rsp !== ersp) begin bad++; $display("FAIL %s_rsp[%0d] got=%h want=%h", name, i, rsp, ersp); end
        end
    endtask

    task automatic test_write_read();
        cmd_t s[$];
        s.push_back(mk(OP_WRITE, $urandom_range(7), 1, 16'd21));
        s.push_back(mk(OP_READ, 1, 0, 16'hFFFF));
        test_directed("write_read", s);
    endtask

    task automatic test_move();
        cmd_t s[$];
        s.push_back(mk(OP_WRITE, 0, 2, 16'd253));
        s.push_back(mk(OP_MOVE, 2, 4, 16'h5555));
        s.push_back(mk(OP_READ, 4, 0, 16'h0));
        s.push_back(mk(OP_READ, 2, 0, 16'h0));
        test_directed("move", s);
    endtask

    task automatic test_swap();
        cmd_t s[$];
        s.push_back(mk(OP_WRITE, 0, 3, 16'h1234));
        s.push_back(mk(OP_WRITE, 0, 5, 16'hABCD));
        s.push_back(mk(OP_SWAP, 3, 5, 16'h0));
        s.push_back(mk(OP_READ, 3, 0, 16'h0));
        s.push_back(mk(OP_READ, 5, 0, 16'h0));
        s.push_back(mk(OP_WRITE, 0, 6, 16'h00FF));
        s.push_back(mk(OP_SWAP, 6, 6, 16'h0));
        s.push_back(mk(OP_READ, 6, 0, 16'h0));
        s.push_back(mk(OP_WRITE, 0, 7, 16'h8001));
        s.push_back(mk(OP_MOVE, 7, 0, 16'h0));
        s.push_back(mk(OP_READ, 0, 7, 16'h0));
        test_directed("swap", s);
    endtask

    task automatic test_busy_hold();
        cmd_t c, rd;
        int lat, elat;
        logic [DW-1:0] ersp, rsp_rd;
        bit to;
        c = mk(OP_SWAP, 3, 5, '0);
        accept_cmd(c, to);
        model_apply(c, elat, ersp);
        total++; if (to) begin bad++; $display("FAIL hold_accept got=timeout want=accept"); end
        for (int k = 1; k <= 5; k++) begin
            total++;
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL hold_busy[%0d] got=ready%b busy%b want=ready0 busy1", k, bus.cmd_ready, bus.busy);
            end
            total++;
            if (bus.rsp_valid !== (k == 5)) begin
                bad++; $display("FAIL hold_rsp_valid[%0d] got=%b want=%b", k, bus.rsp_valid, (k == 5));
            end
            if (k == 5) begin
                total++;
                if (bus.rsp_data !== ersp) begin bad++; $display("FAIL hold_rsp got=%h want=%h", bus.rsp_data, ersp); end
            end
            drive_cmd(mk(2'($urandom_range(3)), $urandom_range(7), $urandom_range(7), 16'($urandom)));
            @(posedge clk);
            #1;
        end
        rd = mk(OP_READ, 5, 0, '0);
        drive_cmd(rd);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL hold_idle got=ready%b busy%b want=ready1 busy0", bus.cmd_ready, bus.busy);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL hold_second_accept got=%b want=1", bus.busy); end
        while (!bus.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rsp_rd = bus.rsp_data;
        model_apply(rd, elat, ersp);
        total++; if (lat !== elat) begin bad++; $display("FAIL hold_second_lat got=%0d want=%0d", lat, elat); end
        total++; if (rsp_rd !== ersp) begin bad++; $display("FAIL hold_second_rsp got=%h want=%h", rsp_rd, ersp); end
    endtask

    task automatic test_reset_mid_swap();
        cmd_t c, s[$];
        bit to;
        c = mk(OP_SWAP, 1, 4, '0);
        accept_cmd(c, to);
        bus.cmd_valid = 1'b0;
        total++; if (to) begin bad++; $display("FAIL rmid_accept got=timeout want=accept"); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.rf_in !== 1'b1) begin bad++; $display("FAIL rmid_swap_wr_in got=%b want=1", bus.rf_in); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rf_in, bus.rf_move, bus.rsp_valid, bus.busy} !== 4'b0000 || bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL rmid_state got=in%b mv%b rv%b busy%b rdy%b want=in0 mv0 rv0 busy0 rdy1",
                            bus.rf_in, bus.rf_move, bus.rsp_valid, bus.busy, bus.cmd_ready);
        end
        total++; if (bus.rsp_data !== '0) begin bad++; $display("FAIL rmid_rsp_data got=%h want=0", bus.rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", bus.cmd_ready); end
        // Only the move half of the swap landed.
        ref_m[c.dst] = ref_m[c.src];
        s.push_back(mk(OP_READ, 1, 0, '0));
        s.push_back(mk(OP_READ, 4, 0, '0));
        test_directed("rmid", s);
    endtask

    task automatic test_random();
        cmd_t s[$];
        for (int r = 0; r < 8; r++) s.push_back(mk(OP_WRITE, 0, r, 16'($urandom)));
        for (int n = 0; n < 40; n++)
            s.push_back(mk(2'($urandom_range(3)), $urandom_range(7), $urandom_range(7), 16'($urandom)));
        test_directed("rand", s);
        repeat (2) @(posedge clk);
        for (int r = 0; r < 8; r++) begin
            total++;
            if (mem[r] !== ref_m[r]) begin bad++; $display("FAIL rand_regfile[%0d] got=%h want=%h", r, mem[r], ref_m[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_move();
        test_swap();
        test_busy_hold();
        test_reset_mid_swap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_xfer_master.md
Name: reg_xfer_master

Overview:
- Command sequencer that drives the 8 x 16-bit register-file port (source, destination, move, in, data_in, data_out) from the requesting side.
- Accepts one high-level command at a time over a valid/ready handshake: WRITE, READ, MOVE or SWAP.
- Expands each command into register-file cycles with correct read timing, and returns a one-cycle response pulse.
- Sits between a control unit or testbench and the register file.

Parameters:
- DW, 16, data width of the register file.
- AW, 3, register index width (2^AW registers).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  command: 0=WRITE, 1=READ, 2=MOVE, 3=SWAP.
- cmd_src  in  AW  source register index.
- cmd_dst  in  AW  destination register index.
- cmd_data  in  DW  write data (WRITE only).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DW  response data.
- busy  out  1  high in any state other than IDLE.
- rf_source  out  AW  to register file source.
- rf_destination  out  AW  to register file destination.
- rf_move  out  1  to register file move.
- rf_in  out  1  to register file in.
- rf_data_in  out  DW  to register file data_in.
- rf_data_out  in  DW  from register file data_out.

Behaviour:
- Register-file contract, sampled at posedge:
  - in=1: reg[destination] <= data_in; data_out goes Z.
  - in=0: data_out <= reg[source]; if move=1, also reg[destination] <= reg[source].
  - Read data is therefore valid in the cycle after the issuing cycle.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - rsp_valid=0, rsp_data=0, busy=0, rf_in=0, rf_move=0, rf_source=0, rf_destination=0, rf_data_in=0, internal temp=0.
  - cmd_ready=1 once in IDLE.
- Handshake:
  - A command is accepted on a posedge with cmd_valid & cmd_ready.
  - op/src/dst/data are latched at acceptance; later changes on cmd_* are ignored.
  - No response backpressure: rsp_valid is a single-cycle pulse.
- rf_* outputs are a pure function of the registered state and the latched command. Default drive in IDLE and CAPTURE: in=0, move=0, source=latched src.
- States and per-state drive:
  - IDLE: cmd_ready=1. On accept, go to ISSUE.
  - ISSUE, by opcode:
    - WRITE: in=1, destination=dst, data_in=data. Next: DONE.
    - READ: in=0, move=0, source=src. Next: CAPTURE.
    - MOVE: in=0, move=1, source=src, destination=dst. Next: CAPTURE.
    - SWAP: in=0, move=0, source=dst. Next: CAPTURE.
  - CAPTURE: holds source unchanged so rf_data_out is stable. At the end edge, latch rf_data_out into temp. SWAP goes to SWAP_MV; all other ops go to DONE.
  - SWAP_MV: in=0, move=1, source=src, destination=dst. Next: SWAP_WR.
  - SWAP_WR: in=1, destination=src, data_in=temp. Next: DONE.
  - DONE: rsp_valid=1. rsp_data is cmd_data for WRITE, otherwise temp. Next: IDLE.
- Latency from accept edge to the rsp_valid cycle: WRITE 2, READ 3, MOVE 3, SWAP 5 cycles.
- Next accept is possible in the cycle after DONE.
- rsp_data holds its last value until the next DONE.
- rf_data_out is never sampled in WRITE or SWAP_WR cycles, because it is Z there.
- Boundary conditions:
  - src==dst on MOVE or SWAP: sequence runs normally; register contents unchanged; rsp_data = reg[src].
  - Index 7 and index 0 have no special meaning.
  - Reset mid-SWAP: the register file may be left partially updated (after SWAP_MV, dst already equals src). This is permitted; no rollback.
  - cmd_valid while busy: ignored; cmd_ready=0.

Decomposition:
- Shared package holds:
  - Opcode constants OP_WRITE/OP_READ/OP_MOVE/OP_SWAP.
  - State encoding (IDLE, ISSUE, CAPTURE, SWAP_MV, SWAP_WR, DONE).
  - Default DW/AW values.
- Single module; no sub-module.
- Bench instantiates the existing register file as the responder.

Test Plan:
1. Reset, then WRITE src=x dst=1 data=21 -> rsp_valid 2 cycles after accept, rsp_data=21. Follow with READ src=1 -> rsp_data=21 after 3 cycles.
2. WRITE r2=253, MOVE src=2 dst=4 -> rsp_data=253. Then READ 4 -> 253 and READ 2 -> 253.
3. WRITE r3=0x1234, r5=0xABCD, then SWAP src=3 dst=5 -> rsp_data=0xABCD. Then READ 3 -> 0xABCD and READ 5 -> 0x1234.
4. SWAP src=6 dst=6 with r6=0x00FF -> rsp_data=0x00FF; READ 6 -> 0x00FF.
5. Hold cmd_valid=1 with changing cmd_* during a SWAP -> cmd_ready=0 and busy=1 for 5 cycles. Second command accepted only in the cycle after DONE; the in-flight result is unaffected.
6. Assert rst_n=0 during SWAP_WR -> state IDLE immediately; rf_in=0, rf_move=0, rsp_valid=0, cmd_ready=1 on release; a new READ works.
